// File: rtl/wb_uart_host_pkg.sv
// Shared constants for the Wishbone UART host: one-hot state encoding and
// the byte-lane select used on every bus cycle.
package wb_uart_host_pkg;

   localparam logic [3:0] ST_IDLE   = 4'b0001;
   localparam logic [3:0] ST_RD     = 4'b0010;
   localparam logic [3:0] ST_WR     = 4'b0100;
   localparam logic [3:0] ST_SETTLE = 4'b1000;

   typedef enum logic [3:0] {
      IDLE   = ST_IDLE,
      RD     = ST_RD,
      WR     = ST_WR,
      SETTLE = ST_SETTLE
   } state_t;

   localparam logic [3:0] WB_SEL = 4'b0001;

endpackage

// File: rtl/wb_uart_gap_timer.sv
// Loadable 16-bit down-counter that paces UART writes. The zero flag is
// registered, so it rises one cycle after the count reaches zero; this gives
// the UART TX engine one extra cycle of margin before the next write.
module wb_uart_gap_timer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] load_val,
   output logic        zero
);

   logic [15:0] count;

   // Count down to zero, reloading when a write finishes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 16'd0;
      end else if (load) begin
         count <= load_val;
      end else if (count != 16'd0) begin
         count <= count - 16'd1;
      end
   end

   // Zero flag trails the count by one cycle and is forced low on a load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero <= 1'b1;
      end else begin
         zero <= !load && (count == 16'd0);
      end
   end

endmodule

// File: rtl/wb_uart_host.sv
// Wishbone initiator servicing one UART: fetches received bytes on irq into a
// one-entry holding register and writes transmit bytes with TX pacing.
//
// Stream handshakes: a transfer happens on a rising clock edge where both
// valid and ready are high; valid never depends combinationally on ready.
module wb_uart_host
   import wb_uart_host_pkg::*;
#(
   parameter logic [31:0] ADR         = 32'h0FF,
   parameter logic [15:0] TX_GAP      = 16'd27500,
   parameter logic [7:0]  ACK_TIMEOUT = 8'd255
) (
   input  logic        clk_48_i,
   input  logic        rst_ni,
   output logic [31:0] adr_o,
   output logic [31:0] dat_o,
   input  logic [31:0] dat_i,
   output logic        we_o,
   output logic        stb_o,
   output logic        cyc_o,
   output logic [3:0]  sel_o,
   input  logic        ack_i,
   input  logic        irq_i,
   output logic [7:0]  rx_data_o,
   output logic        rx_valid_o,
   input  logic        rx_ready_i,
   input  logic [7:0]  tx_data_i,
   input  logic        tx_valid_i,
   output logic        tx_ready_o
   ,
   output logic        err_o
);

   state_t     state;
   state_t     next_state;
   logic [7:0] tmo_cnt;
   logic       rd_req;
   logic       tmo_hit;
   logic       abort;
   logic       gap_load;
   logic       gap_zero;
   logic       next_bus;

   assign adr_o = ADR;

   // A read is wanted whenever the UART has a byte and there is room for it.
   assign rd_req     = irq_i && !rx_valid_o;
   assign tx_ready_o = (state == IDLE) && gap_zero && !rd_req;
   assign tmo_hit    = ((tmo_cnt + 8'd1) == ACK_TIMEOUT);
   assign next_bus   = (next_state == RD) || (next_state == WR);

   wb_uart_gap_timer u_gap (
      .clk      (clk_48_i),
      .rst_n    (rst_ni),
      .load     (gap_load),
      .load_val (TX_GAP),
      .zero     (gap_zero)
   );

   // Next-state logic; a bus cycle ends on ack or after ACK_TIMEOUT cycles.
   always_comb begin
      next_state = state;
      abort      = 1'b0;
      gap_load   = 1'b0;
      unique case (state)
         IDLE: begin
            if (rd_req) begin
               next_state = RD;
            end else if (tx_valid_i && tx_ready_o) begin
               next_state = WR;
            end
         end
         RD: begin
            if (ack_i) begin
               next_state = SETTLE;
            end else if (tmo_hit) begin
               next_state = SETTLE;
               abort      = 1'b1;
            end
         end
         WR: begin
            if (ack_i || tmo_hit) begin
               next_state = SETTLE;
               gap_load   = 1'b1;
               abort      = !ack_i;
            end
         end
         SETTLE:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // State register plus registered bus outputs derived from the next state.
   always_ff @(posedge clk_48_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state   <= IDLE;
         tmo_cnt <= 8'd0;
         cyc_o   <= 1'b0;
         stb_o   <= 1'b0;
         we_o    <= 1'b0;
         sel_o   <= 4'b0000;
         dat_o   <= 32'h0;
         err_o   <= 1'b0;
      end else begin
         state <= next_state;
         cyc_o <= next_bus;
         stb_o <= next_bus;
         we_o  <= (next_state == WR);
         sel_o <= next_bus ? WB_SEL : 4'b0000;
         err_o <= abort;
         if (state != next_state) begin
            tmo_cnt <= 8'd0;
         end else if ((state == RD) || (state == WR)) begin
            tmo_cnt <= tmo_cnt + 8'd1;
         end
         // dat_o doubles as the latch for the byte being written.
         if ((state == IDLE) && (next_state == WR)) begin
            dat_o <= {24'h0, tx_data_i};
         end else if (next_state != WR) begin
            dat_o <= 32'h0;
         end
      end
   end

   // One-entry RX holding register: filled by an acked read, drained by the consumer.
   always_ff @(posedge clk_48_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_data_o  <= 8'h0;
         rx_valid_o <= 1'b0;
      end else begin
         if (rx_valid_o && rx_ready_i) begin
            rx_valid_o <= 1'b0;
         end
         if ((state == RD) && ack_i) begin
            rx_data_o  <= dat_i[7:0];
            rx_valid_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_wb_uart_host.sv
// Bench for wb_uart_host: a registered-ack Wishbone UART model, a table of
// directed RX/TX vectors, and hand-written sequences for pacing, priority,
// backpressure, timeout and asynchronous reset.
module tb_wb_uart_host;
   import wb_uart_host_pkg::*;

   localparam logic [31:0] ADR         = 32'h0FF;
   localparam logic [15:0] TX_GAP      = 16'd20;
   localparam logic [7:0]  ACK_TIMEOUT = 8'd12;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] adr_o, dat_o, dat_i;
   logic        we_o, stb_o, cyc_o, ack_i, irq_i, err_o;
   logic [3:0]  sel_o;
   logic [7:0]  rx_data_o, tx_data_i;
   logic        rx_valid_o, rx_ready_i, tx_valid_i, tx_ready_o;

   int n_checks = 0;
   int n_fail   = 0;

   // UART model state
   logic       ack_en = 1'b1;
   logic       inject_req = 1'b0;
   logic [7:0] inject_byte = 8'h0;
   logic [7:0] uart_rx = 8'h0;
   logic       pending = 1'b0;
   logic       ack_q = 1'b0;
   logic       stb_prev = 1'b0;
   int         reads = 0;
   int         cyc_cnt = 0;
   int         rise_t[$];
   logic [7:0] wr_log[$];
   logic [7:0] exp_q[$];

   typedef struct {
      logic        is_rx;
      logic [7:0]  byte_in;
      logic [31:0] exp_word;
      logic [3:0]  exp_sel;
      logic        exp_we;
      int          exp_lat;
   } vec_t;
   vec_t vecs[6];

   assign ack_i = ack_q;
   assign irq_i = pending;
   assign dat_i = {24'h0, uart_rx};

   wb_uart_host #(
      .ADR         (ADR),
      .TX_GAP      (TX_GAP),
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) dut (
      .clk_48_i   (clk),
      .rst_ni     (rst_n),
      .adr_o      (adr_o),
      .dat_o      (dat_o),
      .dat_i      (dat_i),
      .we_o       (we_o),
      .stb_o      (stb_o),
      .cyc_o      (cyc_o),
      .sel_o      (sel_o),
      .ack_i      (ack_i),
      .irq_i      (irq_i),
      .rx_data_o  (rx_data_o),
      .rx_valid_o (rx_valid_o),
      .rx_ready_i (rx_ready_i),
      .tx_data_i  (tx_data_i),
      .tx_valid_i (tx_valid_i),
      .tx_ready_o (tx_ready_o),
      .err_o      (err_o)
   );

   // Clock
   always #5 clk = ~clk;

   // UART model: registered ack, irq cleared by a read, write/read logging
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_q    <= 1'b0;
         pending  <= 1'b0;
         stb_prev <= 1'b0;
      end else begin
         cyc_cnt  <= cyc_cnt + 1;
         ack_q    <= cyc_o && stb_o && ack_en;
         stb_prev <= stb_o;
         if (stb_o && !stb_prev) rise_t.push_back(cyc_cnt);
         if (cyc_o && stb_o && ack_q && we_o) wr_log.push_back(dat_o[7:0]);
         if (cyc_o && stb_o && ack_q && !we_o) reads <= reads + 1;
         if (inject_req) begin
            pending <= 1'b1;
            uart_rx <= inject_byte;
         end else if (cyc_o && stb_o && !we_o) begin
            pending <= 1'b0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic inject(input logic [7:0] b);
      inject_byte = b;
      inject_req  = 1'b1;
      step();
      inject_req  = 1'b0;
   endtask

   task automatic wait_stb(input string name);
      bit ok;
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         if (stb_o) begin
            ok = 1;
            break;
         end
         step();
      end
      check(name, 32'(ok), 32'd1);
   endtask

   task automatic wait_ready(input string name);
      bit ok;
      ok = 0;
      for (int i = 0; i < int'(TX_GAP) + 40; i++) begin
         if (tx_ready_o) begin
            ok = 1;
            break;
         end
         step();
      end
      check(name, 32'(ok), 32'd1);
   endtask

   // Offer a byte until the handshake edge; returns just after that edge.
   task automatic send_byte(input logic [7:0] b, input string name);
      bit acc;
      acc        = 0;
      tx_data_i  = b;
      tx_valid_i = 1'b1;
      for (int i = 0; i < int'(TX_GAP) + 40; i++) begin
         acc = tx_ready_o;
         step();
         if (acc) break;
      end
      tx_valid_i = 1'b0;
      check(name, 32'(acc), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, r0, cnt, errs;
      rx_ready_i = 1'b1;
      tx_valid_i = 1'b0;
      tx_data_i  = 8'h0;

      vecs[0] = '{1'b1, 8'hA5, 32'h0000_00A5, 4'b0001, 1'b0, 2};
      vecs[1] = '{1'b0, 8'h41, 32'h0000_0041, 4'b0001, 1'b1, 2};
      vecs[2] = '{1'b1, 8'h3C, 32'h0000_003C, 4'b0001, 1'b0, 2};
      vecs[3] = '{1'b0, 8'h42, 32'h0000_0042, 4'b0001, 1'b1, 2};
      vecs[4] = '{1'b1, 8'h00, 32'h0000_0000, 4'b0001, 1'b0, 2};
      vecs[5] = '{1'b0, 8'hFF, 32'h0000_00FF, 4'b0001, 1'b1, 2};

      // Reset state
      step();
      step();
      check("rst_cyc", 32'(cyc_o), 32'd0);
      check("rst_stb", 32'(stb_o), 32'd0);
      check("rst_we", 32'(we_o), 32'd0);
      check("rst_sel", 32'(sel_o), 32'd0);
      check("rst_dat", dat_o, 32'd0);
      check("rst_rx_valid", 32'(rx_valid_o), 32'd0);
      check("rst_rx_data", 32'(rx_data_o), 32'd0);
      check("rst_err", 32'(err_o), 32'd0);
      check("rst_adr", adr_o, ADR);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Table-driven RX and TX transfers
      foreach (vecs[k]) begin
         if (vecs[k].is_rx) begin
            inject(vecs[k].byte_in);
            wait_stb("rx_stb_seen");
            check("rx_sel", 32'(sel_o), 32'(vecs[k].exp_sel));
            check("rx_we", 32'(we_o), 32'(vecs[k].exp_we));
            lat = 0;
            while (!rx_valid_o && lat < 10) begin
               step();
               lat++;
            end
            check("rx_latency", 32'(lat), 32'(vecs[k].exp_lat));
            check("rx_data", 32'(rx_data_o), vecs[k].exp_word);
            check("rx_cyc_dropped", 32'(cyc_o), 32'd0);
         end else begin
            send_byte(vecs[k].byte_in, "tx_accept");
            exp_q.push_back(vecs[k].byte_in);
            check("tx_stb", 32'(stb_o), 32'd1);
            check("tx_we", 32'(we_o), 32'(vecs[k].exp_we));
            check("tx_sel", 32'(sel_o), 32'(vecs[k].exp_sel));
            check("tx_dat", dat_o, vecs[k].exp_word);
            lat = 0;
            while (stb_o && lat < 10) begin
               step();
               lat++;
            end
            check("tx_stb_len", 32'(lat), 32'(vecs[k].exp_lat));
            check("tx_dat_idle", dat_o, 32'd0);
         end
         repeat (4) step();
      end

      // TX pacing: back-to-back offers, strobes spaced TX_GAP+4 cycles
      wait_ready("pace_idle");
      r0 = rise_t.size();
      send_byte(8'h41, "pace_accept0");
      exp_q.push_back(8'h41);
      check("pace_not_ready_in_gap", 32'(tx_ready_o), 32'd0);
      send_byte(8'h42, "pace_accept1");
      exp_q.push_back(8'h42);
      repeat (4) step();
      check("pace_two_strobes", 32'(rise_t.size() - r0), 32'd2);
      if (rise_t.size() >= r0 + 2)
         check("pace_spacing", 32'(rise_t[r0 + 1] - rise_t[r0]), 32'(TX_GAP) + 32'd4);

      // Priority: irq and tx_valid together, read goes first
      wait_ready("prio_idle");
      inject_byte = 8'hC3;
      inject_req  = 1'b1;
      step();
      inject_req  = 1'b0;
      tx_data_i   = 8'h5A;
      tx_valid_i  = 1'b1;
      check("prio_tx_ready_low", 32'(tx_ready_o), 32'd0);
      step();
      check("prio_read_stb", 32'(stb_o), 32'd1);
      check("prio_read_we", 32'(we_o), 32'd0);
      send_byte(8'h5A, "prio_tx_accept");
      exp_q.push_back(8'h5A);
      check("prio_rx_data", 32'(rx_data_o), 32'h0000_00C3);
      check("prio_write_we", 32'(we_o), 32'd1);
      check("prio_write_dat", dat_o, 32'h0000_005A);
      repeat (4) step();

      // Backpressure: second byte waits in the UART until the consumer drains
      wait_ready("bp_idle");
      rx_ready_i = 1'b0;
      inject(8'h11);
      lat = 0;
      while (!rx_valid_o && lat < 10) begin
         step();
         lat++;
      end
      check("bp_first_data", 32'(rx_data_o), 32'h0000_0011);
      r0 = reads;
      inject(8'h22);
      repeat (10) step();
      check("bp_no_read", 32'(reads), 32'(r0));
      check("bp_hold_valid", 32'(rx_valid_o), 32'd1);
      check("bp_hold_data", 32'(rx_data_o), 32'h0000_0011);
      rx_ready_i = 1'b1;
      step();
      lat = 0;
      while (!rx_valid_o && lat < 10) begin
         step();
         lat++;
      end
      check("bp_second_data", 32'(rx_data_o), 32'h0000_0022);
      repeat (10) step();
      check("bp_one_read", 32'(reads), 32'(r0 + 1));

      // Timeout: no ack on a write
      wait_ready("tmo_idle");
      ack_en = 1'b0;
      send_byte(8'h55, "tmo_accept");
      cnt  = 0;
      errs = 0;
      while (cyc_o && cnt < 300) begin
         if (err_o) errs++;
         step();
         cnt++;
      end
      check("tmo_cyc_cycles", 32'(cnt), 32'(ACK_TIMEOUT));
      check("tmo_no_early_err", 32'(errs), 32'd0);
      check("tmo_err_pulse", 32'(err_o), 32'd1);
      check("tmo_stb_low", 32'(stb_o), 32'd0);
      step();
      check("tmo_err_one_cycle", 32'(err_o), 32'd0);
      check("tmo_state_idle", 32'(dut.state), 32'(ST_IDLE));
      check("tmo_gap_loaded", 32'(tx_ready_o), 32'd0);
      ack_en = 1'b1;

      // Reset in the middle of a read drops the bus without a clock edge
      repeat (2) step();
      inject(8'h77);
      wait_stb("rstmid_stb_seen");
      #2;
      rst_n = 1'b0;
      #1;
      check("rstmid_cyc", 32'(cyc_o), 32'd0);
      check("rstmid_stb", 32'(stb_o), 32'd0);
      check("rstmid_rx_valid", 32'(rx_valid_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) step();

      // Scoreboard: every accepted TX byte written exactly once, in order
      check("sb_write_count", 32'(wr_log.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++)
         check("sb_write_byte", 32'(wr_log[i]), 32'(exp_q[i]));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
